// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
package fifo_pkg;

  localparam int unsigned FIFO_MODE_STD  = 0;
  localparam int unsigned FIFO_MODE_FWFT = 1;

  // Registered status bits, all derived from the next occupancy or the accept rules
  typedef struct packed {
    logic empty;
    logic full;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_flags_t;

  // Occupancy counter width: one extra bit so DEPTH itself is representable
  function automatic int unsigned cnt_w(input int unsigned aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, threshold flags,
// overflow/underflow pulses and optional first-word-fall-through read.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned AW       = 4,
  parameter int unsigned AF_LEVEL = 12,
  parameter int unsigned AE_LEVEL = 4,
  parameter int unsigned FWFT     = FIFO_MODE_STD
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      Din,
  input  logic                  Wen,
  input  logic                  Ren,
  output logic [WIDTH-1:0]      Dout,
  output logic                  Fempty,
  output logic                  Ffull,
  output logic [cnt_w(AW)-1:0]  Count,
  output logic                  Falmost_full,
  output logic                  Falmost_empty,
  output logic                  Overflow,
  output logic                  Underflow
);

  localparam int unsigned CW    = cnt_w(AW);
  localparam int unsigned DEPTH = 1 << AW;

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  fifo_flags_t      flags_q, flags_d;
  logic             wr_ok, rd_ok;
  logic [WIDTH-1:0] rdata;

  fifo_mem #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk     (ck),
    .we_i    (wr_ok),
    .waddr_i (wptr_q),
    .wdata_i (Din),
    .raddr_i (rptr_q),
    .rdata_o (rdata)
  );

  // A full FIFO still accepts a write when a read frees a slot on the same edge
  always_comb begin
    rd_ok = Ren & ~flags_q.empty;
    wr_ok = Wen & (~flags_q.full | rd_ok);
  end

  // Next pointers, occupancy and flags; flags are derived from the next count
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    flags_d = '0;

    if (wr_ok) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (rd_ok) begin
      rptr_d = rptr_q + AW'(1);
    end

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    flags_d.empty        = (count_d == '0);
    flags_d.full         = (count_d == CW'(DEPTH));
    flags_d.almost_full  = (count_d >= CW'(AF_LEVEL));
    flags_d.almost_empty = (count_d <= CW'(AE_LEVEL));
    flags_d.overflow     = Wen & flags_q.full & ~rd_ok;
    flags_d.underflow    = Ren & flags_q.empty;
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      wptr_q                <= '0;
      rptr_q                <= '0;
      count_q               <= '0;
      flags_q               <= '0;
      flags_q.empty         <= 1'b1;
      flags_q.almost_empty  <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      flags_q <= flags_d;
    end
  end

  // Read data path: head word shown directly in FWFT mode, else captured on a pop
  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign Dout = flags_q.empty ? '0 : rdata;
  end else begin : g_std
    logic [WIDTH-1:0] dout_q, dout_d;

    always_comb begin
      dout_d = dout_q;
      if (rd_ok) begin
        dout_d = rdata;
      end
    end

    always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
        dout_q <= '0;
      end else begin
        dout_q <= dout_d;
      end
    end

    assign Dout = dout_q;
  end

  assign Count         = count_q;
  assign Fempty        = flags_q.empty;
  assign Ffull         = flags_q.full;
  assign Falmost_full  = flags_q.almost_full;
  assign Falmost_empty = flags_q.almost_empty;
  assign Overflow      = flags_q.overflow;
  assign Underflow     = flags_q.underflow;

endmodule
